// File: rtl/alu_scalar_seq_module.sv
// Sequential DIM x DIM matrix-by-scalar multiplier, LANES elements per beat, start/busy/done handshake.
// Optional build macro ALU_SCALAR_SAT_EN: overflowing elements saturate instead of wrapping.
module alu_scalar_seq_module #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5,
    parameter int LANES  = 5,
    localparam int NELEM = DIM * DIM,
    localparam int BEATS = NELEM / LANES,
    localparam int MAT_W = NELEM * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MAT_W-1:0]  A_flat,
    input  logic [DATA_W-1:0] scalar,
    output logic [MAT_W-1:0]  C_flat,
    output logic              overflow_flag,
    output logic              busy,
    output logic              done
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [MAT_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]   s_q, s_d;
    logic [MAT_W-1:0]    c_q, c_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Returns {overflow, result element} for one lane; the product is kept at full 2*DATA_W precision.
    function automatic logic [DATA_W:0] lane_calc(input logic signed [DATA_W-1:0] elem,
                                                  input logic signed [DATA_W-1:0] scl);
        logic signed [2*DATA_W-1:0] prod;
        logic                       ovf;
        logic [DATA_W-1:0]          res;
        prod = elem * scl;
        ovf  = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
`ifdef ALU_SCALAR_SAT_EN
        if (ovf) begin
            res = prod[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            res = prod[DATA_W-1:0];
        end
`else
        res = prod[DATA_W-1:0];
`endif
        return {ovf, res};
    endfunction

    always_comb begin
        logic [DATA_W:0] lane_out;
        int              idx;
        state_d  = state_q;
        beat_d   = beat_q;
        a_d      = a_q;
        s_d      = s_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        lane_out = '0;
        idx      = 0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = A_flat;
                    s_d     = scalar;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    idx      = int'(beat_q) * LANES + l;
                    lane_out = lane_calc(a_q[idx*DATA_W +: DATA_W], s_q);
                    c_d[idx*DATA_W +: DATA_W] = lane_out[DATA_W-1:0];
                    ovf_d    = ovf_d | lane_out[DATA_W];
                end
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign C_flat        = c_q;
    assign overflow_flag = ovf_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_alu_scalar_seq_module.sv
// Directed self-checking bench for alu_scalar_seq_module (DATA_W=8, DIM=5, LANES=5).
// Expected wrap/saturate values follow the ALU_SCALAR_SAT_EN build macro.
module tb_alu_scalar_seq_module;

    localparam int DATA_W = 8;
    localparam int NELEM  = 25;
    localparam int MAT_W  = NELEM * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [MAT_W-1:0]  A_flat = '0;
    logic [DATA_W-1:0] scalar = '0;
    logic [MAT_W-1:0]  C_flat;
    logic              overflow_flag;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    alu_scalar_seq_module #(.DATA_W(8), .DIM(5), .LANES(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .A_flat        (A_flat),
        .scalar        (scalar),
        .C_flat        (C_flat),
        .overflow_flag (overflow_flag),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [MAT_W-1:0] observed,
                               input logic [MAT_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [MAT_W-1:0] fill(input logic [DATA_W-1:0] v);
        logic [MAT_W-1:0] m;
        for (int i = 0; i < NELEM; i++) m[i*DATA_W +: DATA_W] = v;
        return m;
    endfunction

    // Pulses start with the given operands, scrambles the inputs afterwards, optionally
    // injects a start pulse mid-run, and waits (bounded) for done, counting busy cycles.
    task automatic applyStimulus(input logic [MAT_W-1:0] mat, input logic [DATA_W-1:0] sc,
                                 input bit inject, output int busy_cycles, output bit got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        @(negedge clk);
        A_flat = mat;
        scalar = sc;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        A_flat = ~mat;
        scalar = sc + 8'd3;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            start = inject && (busy_cycles == 2);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    logic [MAT_W-1:0] exp_m;
    logic [MAT_W-1:0] ramp;
    int               bc;
    bit               gd;
    int               gap;
    bit               seen_done;

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        checkOutput("reset_C", C_flat, '0);
        checkOutput("reset_ovf", MAT_W'(overflow_flag), '0);
        checkOutput("reset_busy", MAT_W'(busy), '0);
        checkOutput("reset_done", MAT_W'(done), '0);
        rst = 1'b0;

        // 1: all 3 * 4, with an ignored start pulse mid-run
        applyStimulus(fill(8'd3), 8'd4, 1'b1, bc, gd);
        checkOutput("t1_done_seen", MAT_W'(gd), MAT_W'(1));
        checkOutput("t1_busy_cycles", MAT_W'(bc), MAT_W'(5));
        checkOutput("t1_C", C_flat, fill(8'h0C));
        checkOutput("t1_ovf", MAT_W'(overflow_flag), '0);
        @(negedge clk);
        checkOutput("t1_done_one_cycle", MAT_W'(done), '0);
        repeat (3) @(negedge clk);
        checkOutput("t1_C_hold", C_flat, fill(8'h0C));
        checkOutput("t1_idle_busy", MAT_W'(busy), '0);

        // 2: A[0]=100 * 2 overflows
        exp_m = '0;
`ifdef ALU_SCALAR_SAT_EN
        exp_m[7:0] = 8'h7F;
`else
        exp_m[7:0] = 8'hC8;
`endif
        applyStimulus(MAT_W'(100), 8'd2, 1'b0, bc, gd);
        checkOutput("t2_done_seen", MAT_W'(gd), MAT_W'(1));
        checkOutput("t2_C", C_flat, exp_m);
        checkOutput("t2_ovf", MAT_W'(overflow_flag), MAT_W'(1));

        // 3: A[24]=-128 * -1 overflows
        ramp = '0;
        ramp[24*8 +: 8] = 8'h80;
        exp_m = '0;
`ifdef ALU_SCALAR_SAT_EN
        exp_m[24*8 +: 8] = 8'h7F;
`else
        exp_m[24*8 +: 8] = 8'h80;
`endif
        applyStimulus(ramp, 8'hFF, 1'b0, bc, gd);
        checkOutput("t3_C", C_flat, exp_m);
        checkOutput("t3_ovf", MAT_W'(overflow_flag), MAT_W'(1));

        // 4: negative products inside range, including exactly -128
        applyStimulus(fill(8'hFB), 8'd7, 1'b0, bc, gd);
        checkOutput("t4a_C", C_flat, fill(8'hDD));
        checkOutput("t4a_ovf", MAT_W'(overflow_flag), '0);
        applyStimulus(fill(8'hF0), 8'd8, 1'b0, bc, gd);
        checkOutput("t4b_C", C_flat, fill(8'h80));
        checkOutput("t4b_ovf", MAT_W'(overflow_flag), '0);

        // Boundaries: scalar=1 gives C=A, scalar=0 gives C=0
        for (int i = 0; i < NELEM; i++) ramp[i*8 +: 8] = 8'(i * 10 - 120);
        ramp[7:0] = 8'h80;
        applyStimulus(ramp, 8'd1, 1'b0, bc, gd);
        checkOutput("s1_C", C_flat, ramp);
        checkOutput("s1_ovf", MAT_W'(overflow_flag), '0);
        applyStimulus(ramp, 8'd0, 1'b0, bc, gd);
        checkOutput("s0_C", C_flat, '0);
        checkOutput("s0_ovf", MAT_W'(overflow_flag), '0);

        // 5: reset at beat 2 abandons the operation
        @(negedge clk);
        A_flat = fill(8'd3);
        scalar = 8'd4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_busy", MAT_W'(busy), '0);
        checkOutput("t5_C", C_flat, '0);
        checkOutput("t5_ovf", MAT_W'(overflow_flag), '0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        checkOutput("t5_no_done", MAT_W'(seen_done), '0);

        // 6: back-to-back, start held during the first done cycle
        applyStimulus(MAT_W'(100), 8'd2, 1'b0, bc, gd);
        checkOutput("t6_first_ovf", MAT_W'(overflow_flag), MAT_W'(1));
        A_flat = fill(8'hFB);
        scalar = 8'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t6_ovf_cleared", MAT_W'(overflow_flag), '0);
        checkOutput("t6_busy", MAT_W'(busy), MAT_W'(1));
        gap = 1;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            gap++;
            @(negedge clk);
        end
        checkOutput("t6_done_gap", MAT_W'(gap), MAT_W'(6));
        checkOutput("t6_C", C_flat, fill(8'hDD));
        checkOutput("t6_ovf", MAT_W'(overflow_flag), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
